// File: rtl/rv32_control_fsm.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer for the RV32I core.
// Optional performance counters are enabled with the RV32_PERF_CNT_EN macro.
module rv32_control_fsm #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  o_imem_req,
    input  logic                  i_imem_ack,
    input  logic [DATA_WIDTH-1:0] i_imem_rdata,
    output logic [DATA_WIDTH-1:0] o_ir,
    input  logic                  i_branch_taken,
    output logic                  o_pc_en,
    output logic                  o_pc_load,
    output logic                  o_rf_we,
    output logic                  o_dmem_req,
    output logic                  o_dmem_we,
    input  logic                  i_dmem_ack,
    output logic                  o_halt,
    output logic                  o_trap,
    output logic [2:0]            o_state,
    output logic [CNT_WIDTH-1:0]  o_cycle_cnt,
    output logic [CNT_WIDTH-1:0]  o_instret
);

    localparam logic [2:0] StReset   = 3'd0;
    localparam logic [2:0] StFetch   = 3'd1;
    localparam logic [2:0] StDecode  = 3'd2;
    localparam logic [2:0] StExecute = 3'd3;
    localparam logic [2:0] StMem     = 3'd4;
    localparam logic [2:0] StWb      = 3'd5;
    localparam logic [2:0] StHalt    = 3'd6;

    localparam logic [6:0] OpLoad   = 7'h03;
    localparam logic [6:0] OpStore  = 7'h23;
    localparam logic [6:0] OpBranch = 7'h63;
    localparam logic [6:0] OpJal    = 7'h6F;
    localparam logic [6:0] OpJalr   = 7'h67;
    localparam logic [6:0] OpOp     = 7'h33;
    localparam logic [6:0] OpOpImm  = 7'h13;
    localparam logic [6:0] OpLui    = 7'h37;
    localparam logic [6:0] OpAuipc  = 7'h17;
    localparam logic [6:0] OpFence  = 7'h0F;
    localparam logic [6:0] OpSystem = 7'h73;

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [DATA_WIDTH-1:0] r_ir;
    logic                  r_halt;
    logic                  r_trap;
    logic                  w_set_halt;
    logic                  w_set_trap;
    logic [6:0]            w_opcode;
    logic                  w_legal;
    logic                  w_is_mem;
    logic                  w_is_store;
    logic                  w_is_jump;

    assign w_opcode   = r_ir[6:0];
    assign w_is_store = (w_opcode == OpStore);
    assign w_is_mem   = (w_opcode == OpLoad) || w_is_store;
    assign w_is_jump  = (w_opcode == OpJal) || (w_opcode == OpJalr);

    always_comb begin
        w_legal = 1'b0;
        case (w_opcode)
            OpLoad, OpStore, OpBranch, OpJal, OpJalr, OpOp, OpOpImm,
            OpLui, OpAuipc, OpFence, OpSystem: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_set_halt   = 1'b0;
        w_set_trap   = 1'b0;
        case (r_state)
            StReset: w_state_next = StFetch;
            StFetch: if (i_imem_ack) w_state_next = StDecode;
            StDecode: begin
                if (!w_legal || w_opcode == OpSystem) begin
                    w_state_next = StHalt;
                    w_set_halt   = 1'b1;
                    w_set_trap   = !w_legal;
                end else begin
                    w_state_next = StExecute;
                end
            end
            StExecute: begin
                if (w_is_mem) begin
                    w_state_next = StMem;
                end else if (w_opcode == OpBranch || w_opcode == OpFence) begin
                    w_state_next = StFetch;
                end else begin
                    w_state_next = StWb;
                end
            end
            StMem: if (i_dmem_ack) w_state_next = w_is_store ? StFetch : StWb;
            StWb: w_state_next = StFetch;
            StHalt: w_state_next = StHalt;
            default: w_state_next = StReset;
        endcase
    end

    // Exactly one PC pulse per retired instruction; the two are mutually exclusive.
    always_comb begin
        o_imem_req = (r_state == StFetch);
        o_dmem_req = (r_state == StMem);
        o_dmem_we  = (r_state == StMem) && w_is_store;
        o_rf_we    = (r_state == StWb) && (r_ir[11:7] != 5'd0);
        o_pc_en    = 1'b0;
        o_pc_load  = 1'b0;
        case (r_state)
            StExecute: begin
                if (w_opcode == OpBranch) begin
                    o_pc_load = i_branch_taken;
                    o_pc_en   = !i_branch_taken;
                end else if (w_opcode == OpFence) begin
                    o_pc_en = 1'b1;
                end
            end
            StMem: o_pc_en = w_is_store && i_dmem_ack;
            StWb: begin
                o_pc_load = w_is_jump;
                o_pc_en   = !w_is_jump;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StReset;
            r_ir    <= '0;
            r_halt  <= 1'b0;
            r_trap  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StFetch && i_imem_ack) r_ir <= i_imem_rdata;
            if (w_set_halt) r_halt <= 1'b1;
            if (w_set_trap) r_trap <= 1'b1;
        end
    end

    assign o_ir    = r_ir;
    assign o_halt  = r_halt;
    assign o_trap  = r_trap;
    assign o_state = r_state;

`ifdef RV32_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_cycle_cnt;
    logic [CNT_WIDTH-1:0] r_instret;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt <= '0;
            r_instret   <= '0;
        end else begin
            if (r_state != StReset && r_state != StHalt) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_WIDTH'(1);
            end
            if (o_pc_en || o_pc_load) r_instret <= r_instret + CNT_WIDTH'(1);
        end
    end

    assign o_cycle_cnt = r_cycle_cnt;
    assign o_instret   = r_instret;
`else
    assign o_cycle_cnt = '0;
    assign o_instret   = '0;
`endif

endmodule
